// File: rtl/rf_writeback_unit_if.sv
// ============================================================================
// Module      : rf_writeback_unit_if
// Description : Bundle of the handshake and register-file write-port signals
//               around rf_writeback_unit.
//               slave  - view taken by rf_writeback_unit
//               master - view taken by the surrounding core / testbench
//               Optional macro RF_WB_BYPASS_EN adds the read-forwarding
//               signals (ra1/ra2, rd1_in/rd2_in, rd1_fwd/rd2_fwd).
// Signals     : alu_valid/alu_rd/alu_wd/alu_ready   ALU result handshake
//               ld_issue/ld_issue_rd                load issue notification
//               lsu_valid/lsu_rd/lsu_wd/lsu_ready   load data handshake
//               a3/we3/wd3                          register file write port
//               pending                             outstanding-load bitmap
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_writeback_unit_if;

    // ALU result stream
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        alu_ready;

    // Load issue notification from the LSU front end
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;

    // Load data return stream
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wd;
    logic        lsu_ready;

    // Register file write port
    logic [4:0]  a3;
    logic        we3;
    logic [31:0] wd3;

    // Outstanding-load scoreboard for decode
    logic [31:0] pending;

`ifdef RF_WB_BYPASS_EN
    // Read forwarding around the register file
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1_in;
    logic [31:0] rd2_in;
    logic [31:0] rd1_fwd;
    logic [31:0] rd2_fwd;
`endif

    modport slave (
`ifdef RF_WB_BYPASS_EN
        input  ra1, ra2, rd1_in, rd2_in,
        output rd1_fwd, rd2_fwd,
`endif
        input  alu_valid, alu_rd, alu_wd,
        output alu_ready,
        input  ld_issue, ld_issue_rd,
        input  lsu_valid, lsu_rd, lsu_wd,
        output lsu_ready,
        output a3, we3, wd3,
        output pending
    );

    modport master (
`ifdef RF_WB_BYPASS_EN
        output ra1, ra2, rd1_in, rd2_in,
        input  rd1_fwd, rd2_fwd,
`endif
        output alu_valid, alu_rd, alu_wd,
        input  alu_ready,
        output ld_issue, ld_issue_rd,
        output lsu_valid, lsu_rd, lsu_wd,
        input  lsu_ready,
        input  a3, we3, wd3,
        input  pending
    );

endinterface

`default_nettype wire

// File: rtl/rf_writeback_unit.sv
// ============================================================================
// Module      : rf_writeback_unit
// Description : Write-side companion of the 32x32 register file and sole
//               driver of its write port. ALU results are buffered in a small
//               FIFO and always have priority; load data from the LSU is
//               written straight through (zero latency) whenever the FIFO is
//               empty. A pending-load scoreboard tells decode which registers
//               still await load data, and blocks ALU results targeting such
//               a register so writes to one rd always retire in order.
// Parameters  : FIFO_DEPTH - ALU result FIFO entries (power of two, >= 2)
// Ports       : i_clk   - core clock, rising edge
//               i_rst_n - asynchronous active-low reset
//               wb      - rf_writeback_unit_if.slave bundle:
//                         ALU handshake, load issue, LSU handshake,
//                         register file write port (a3/we3/wd3), pending
// Options     : RF_WB_BYPASS_EN - when defined, adds same-cycle
//               write-to-read forwarding (ra1/ra2, rd1_in/rd2_in ->
//               rd1_fwd/rd2_fwd). When undefined those signals are absent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_writeback_unit #(
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst_n,
    rf_writeback_unit_if.slave wb
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // ALU result FIFO state
    // ------------------------------------------------------------------------
    logic [4:0]         r_fifo_rd [FIFO_DEPTH];
    logic [31:0]        r_fifo_wd [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;

    // ------------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------------
    logic [31:0] r_pending;
    logic [31:0] w_pend_set;
    logic [31:0] w_pend_clr;
    logic [31:0] w_pending_nxt;

    // ------------------------------------------------------------------------
    // Handshake / write-port wires
    // ------------------------------------------------------------------------
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_alu_rd_pending;
    logic        w_alu_ready;
    logic        w_lsu_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_lsu_accept;
    logic [4:0]  w_head_rd;
    logic [31:0] w_head_wd;
    logic [4:0]  w_a3;
    logic        w_we3;
    logic [31:0] w_wd3;

    // ------------------------------------------------------------------------
    // Handshake decisions
    // ------------------------------------------------------------------------
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_CNT_FULL);

    // An ALU result for a register with a load still in flight must wait:
    // letting it through would allow the older load to overwrite it later.
    assign w_alu_rd_pending = r_pending[wb.alu_rd] & (wb.alu_rd != 5'd0);

    // Readies are forced low while reset is asserted. The full check uses the
    // registered occupancy only, so a full FIFO blocks for a cycle even when
    // its head drains in that same cycle (no ready-from-pop path).
    assign w_alu_ready  = i_rst_n & ~w_fifo_full & ~w_alu_rd_pending;
    assign w_lsu_ready  = i_rst_n & w_fifo_empty;

    assign w_push       = wb.alu_valid & w_alu_ready;
    // The head is written every cycle it exists, so it always pops.
    assign w_pop        = ~w_fifo_empty;
    assign w_lsu_accept = wb.lsu_valid & w_lsu_ready;

    assign w_head_rd    = r_fifo_rd[r_rd_ptr];
    assign w_head_wd    = r_fifo_wd[r_rd_ptr];

    // ------------------------------------------------------------------------
    // Write-port select. FIFO head first; LSU only when the FIFO is empty.
    // x0 targets complete their handshake but never raise we3.
    // During reset the FIFO is empty and w_lsu_accept is low, so the port
    // idles at zero.
    // ------------------------------------------------------------------------
    always_comb begin
        w_a3  = 5'd0;
        w_we3 = 1'b0;
        w_wd3 = 32'd0;
        if (!w_fifo_empty) begin
            w_a3  = w_head_rd;
            w_wd3 = w_head_wd;
            w_we3 = (w_head_rd != 5'd0);
        end else if (w_lsu_accept) begin
            w_a3  = wb.lsu_rd;
            w_wd3 = wb.lsu_wd;
            w_we3 = (wb.lsu_rd != 5'd0);
        end
    end

    // ------------------------------------------------------------------------
    // FIFO occupancy
    // ------------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;   // idle, or push+pop balanced
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Depth is a power of two, so pointer wrap is natural overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // FIFO storage carries no reset: contents are only observed through the
    // occupancy count, which is reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr] <= wb.alu_rd;
            r_fifo_wd[r_wr_ptr] <= wb.alu_wd;
        end
    end

    // ------------------------------------------------------------------------
    // Pending-load scoreboard. Clear is applied before set, so a new load
    // issued in the same cycle its predecessor returns keeps the bit high.
    // Bit 0 is masked off permanently.
    // ------------------------------------------------------------------------
    assign w_pend_set    = (wb.ld_issue && (wb.ld_issue_rd != 5'd0)) ?
                           (32'd1 << wb.ld_issue_rd) : 32'd0;
    assign w_pend_clr    = w_lsu_accept ? (32'd1 << wb.lsu_rd) : 32'd0;
    assign w_pending_nxt = ((r_pending & ~w_pend_clr) | w_pend_set) & ~32'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wb.alu_ready = w_alu_ready;
    assign wb.lsu_ready = w_lsu_ready;
    assign wb.a3        = w_a3;
    assign wb.we3       = w_we3;
    assign wb.wd3       = w_wd3;
    assign wb.pending   = r_pending;

`ifdef RF_WB_BYPASS_EN
    // ------------------------------------------------------------------------
    // Same-cycle write-to-read forwarding: a read of the register being
    // written this cycle sees the new value. x0 is never forwarded.
    // ------------------------------------------------------------------------
    assign wb.rd1_fwd = (w_we3 && (w_a3 == wb.ra1) && (wb.ra1 != 5'd0)) ?
                        w_wd3 : wb.rd1_in;
    assign wb.rd2_fwd = (w_we3 && (w_a3 == wb.ra2) && (wb.ra2 != 5'd0)) ?
                        w_wd3 : wb.rd2_in;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_unit.sv
// ============================================================================
// Module      : tb_rf_writeback_unit
// Description : Self-checking bench for rf_writeback_unit (FIFO_DEPTH = 2).
//               A cycle-by-cycle vector table drives the ALU, load-issue and
//               LSU inputs and holds hand-computed write-port, ready and
//               scoreboard values; a hand-written sequence covers an
//               asynchronous reset in the middle of traffic. A small register
//               file model records committed writes. Forwarding outputs are
//               checked when RF_WB_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_writeback_unit;

    localparam logic [31:0] c_F1 = 32'hDEAD_0001;   // rd1_in value
    localparam logic [31:0] c_F2 = 32'hDEAD_0002;   // rd2_in value

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_wd;
        logic        ld_v;
        logic [4:0]  ld_rd;
        logic        lsu_v;
        logic [4:0]  lsu_rd;
        logic [31:0] lsu_wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        e_alu_rdy;
        logic        e_lsu_rdy;
        logic        e_we3;
        logic [4:0]  e_a3;
        logic [31:0] e_wd3;
        logic [31:0] e_pend;
        logic [31:0] e_fwd1;
        logic [31:0] e_fwd2;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          n_checks;
    int          n_errors;
    logic [31:0] rf_model [32];
    vec_t        vecs [21];

    rf_writeback_unit_if wb_if ();

    rf_writeback_unit #(
        .FIFO_DEPTH (2)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: commits whatever the write port presents at the edge.
    always @(posedge clk) begin
        if (wb_if.we3) begin
            rf_model[wb_if.a3] <= wb_if.wd3;
        end
    end

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp_v);
        end
    endtask

    function automatic vec_t mkv(
        input logic av, input logic [4:0] ar, input logic [31:0] aw,
        input logic lv, input logic [4:0] lr,
        input logic sv, input logic [4:0] sr, input logic [31:0] sw,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic ear, input logic elr, input logic ewe,
        input logic [4:0] ea3, input logic [31:0] ewd, input logic [31:0] ep,
        input logic [31:0] ef1, input logic [31:0] ef2);
        vec_t v;
        v.alu_v = av;  v.alu_rd = ar;  v.alu_wd = aw;
        v.ld_v  = lv;  v.ld_rd  = lr;
        v.lsu_v = sv;  v.lsu_rd = sr;  v.lsu_wd = sw;
        v.ra1   = r1;  v.ra2    = r2;
        v.e_alu_rdy = ear; v.e_lsu_rdy = elr; v.e_we3 = ewe;
        v.e_a3  = ea3; v.e_wd3  = ewd; v.e_pend = ep;
        v.e_fwd1 = ef1; v.e_fwd2 = ef2;
        return v;
    endfunction

    task automatic drive_idle();
        wb_if.alu_valid   = 1'b0;
        wb_if.alu_rd      = 5'd0;
        wb_if.alu_wd      = 32'd0;
        wb_if.ld_issue    = 1'b0;
        wb_if.ld_issue_rd = 5'd0;
        wb_if.lsu_valid   = 1'b0;
        wb_if.lsu_rd      = 5'd0;
        wb_if.lsu_wd      = 32'd0;
`ifdef RF_WB_BYPASS_EN
        wb_if.ra1    = 5'd0;
        wb_if.ra2    = 5'd0;
        wb_if.rd1_in = c_F1;
        wb_if.rd2_in = c_F2;
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;

        //                av  ard    awd            lv  lrd   sv  srd    swd           ra1   ra2   ar   lr   we   a3     wd3            pend          fwd1          fwd2
        // Single ALU write, one-cycle latency
        vecs[0]  = mkv(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1,1'b1,1'b0, 5'd0,  32'h0,         32'h0,        c_F1,         c_F2);
        vecs[1]  = mkv(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,         5'd0, 5'd5, 1'b1,1'b0,1'b1, 5'd5,  32'h0000_00AA, 32'h0,        c_F1,         32'h0000_00AA);
        vecs[2]  = mkv(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1,1'b1,1'b0, 5'd0,  32'h0,         32'h0,        c_F1,         c_F2);
        // ALU stream x1..x4 starves a waiting load until the FIFO drains
        vecs[3]  = mkv(1'b1, 5'd1, 32'h11,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1,1'b1,1'b0, 5'd0,  32'h0,         32'h0,        c_F1,         c_F2);
        vecs[4]  = mkv(1'b1, 5'd2, 32'h22,        1'b0, 5'd0, 1'b1, 5'd10,32'h1000,      5'd0, 5'd0, 1'b1,1'b0,1'b1, 5'd1,  32'h11,        32'h0,        c_F1,         c_F2);
        vecs[5]  = mkv(1'b1, 5'd3, 32'h33,        1'b0, 5'd0, 1'b1, 5'd10,32'h1000,      5'd0, 5'd0, 1'b1,1'b0,1'b1, 5'd2,  32'h22,        32'h0,        c_F1,         c_F2);
        vecs[6]  = mkv(1'b1, 5'd4, 32'h44,        1'b0, 5'd0, 1'b1, 5'd10,32'h1000,      5'd0, 5'd0, 1'b1,1'b0,1'b1, 5'd3,  32'h33,        32'h0,        c_F1,         c_F2);
        vecs[7]  = mkv(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b1, 5'd10,32'h1000,      5'd0, 5'd0, 1'b1,1'b0,1'b1, 5'd4,  32'h44,        32'h0,        c_F1,         c_F2);
        vecs[8]  = mkv(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b1, 5'd10,32'h1000,      5'd0, 5'd0, 1'b1,1'b1,1'b1, 5'd10, 32'h1000,      32'h0,        c_F1,         c_F2);
        // Scoreboard: load to x7 blocks ALU x7 until the load data returns
        vecs[9]  = mkv(1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1,1'b1,1'b0, 5'd0,  32'h0,         32'h0,        c_F1,         c_F2);
        vecs[10] = mkv(1'b1, 5'd7, 32'h77,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,         5'd7, 5'd0, 1'b0,1'b1,1'b0, 5'd0,  32'h0,         32'h0000_0080,c_F1,         c_F2);
        vecs[11] = mkv(1'b1, 5'd7, 32'h77,        1'b0, 5'd0, 1'b1, 5'd7, 32'h1234,      5'd0, 5'd7, 1'b0,1'b1,1'b1, 5'd7,  32'h1234,      32'h0000_0080,c_F1,         32'h1234);
        vecs[12] = mkv(1'b1, 5'd7, 32'h77,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1,1'b1,1'b0, 5'd0,  32'h0,         32'h0,        c_F1,         c_F2);
        vecs[13] = mkv(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,         5'd7, 5'd0, 1'b1,1'b0,1'b1, 5'd7,  32'h77,        32'h0,        32'h77,       c_F2);
        // x0: handshake completes, no write, no scoreboard bit
        vecs[14] = mkv(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1,1'b1,1'b0, 5'd0,  32'h0,         32'h0,        c_F1,         c_F2);
        vecs[15] = mkv(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1,1'b0,1'b0, 5'd0,  32'hFFFF_FFFF, 32'h0,        c_F1,         c_F2);
        vecs[16] = mkv(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1,1'b1,1'b0, 5'd0,  32'h0,         32'h0,        c_F1,         c_F2);
        // Same-cycle set and clear of x9: set wins
        vecs[17] = mkv(1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1,1'b1,1'b0, 5'd0,  32'h0,         32'h0,        c_F1,         c_F2);
        vecs[18] = mkv(1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 1'b1, 5'd9, 32'h9999,      5'd9, 5'd0, 1'b1,1'b1,1'b1, 5'd9,  32'h9999,      32'h0000_0200,32'h9999,     c_F2);
        vecs[19] = mkv(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b1, 5'd9, 32'h5,         5'd9, 5'd0, 1'b1,1'b1,1'b1, 5'd9,  32'h5,         32'h0000_0200,32'h5,        c_F2);
        vecs[20] = mkv(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 1'b0, 5'd0, 32'h0,         5'd9, 5'd0, 1'b1,1'b1,1'b0, 5'd0,  32'h0,         32'h0,        c_F1,         c_F2);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        drive_idle();
        wb_if.lsu_valid = 1'b1;        // readies/write port must stay idle anyway
        wb_if.lsu_rd    = 5'd3;
        wb_if.alu_valid = 1'b1;
        #3;
        chk("rst_alu_ready", 0, {31'd0, wb_if.alu_ready}, 32'd0);
        chk("rst_lsu_ready", 0, {31'd0, wb_if.lsu_ready}, 32'd0);
        chk("rst_we3",       0, {31'd0, wb_if.we3},       32'd0);
        chk("rst_a3",        0, {27'd0, wb_if.a3},        32'd0);
        chk("rst_wd3",       0, wb_if.wd3,                32'd0);
        chk("rst_pending",   0, wb_if.pending,            32'd0);
        drive_idle();
        #9;
        rst_n = 1'b1;                  // t=12, away from edges
        @(posedge clk);
        #1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 21; i++) begin
            wb_if.alu_valid   = vecs[i].alu_v;
            wb_if.alu_rd      = vecs[i].alu_rd;
            wb_if.alu_wd      = vecs[i].alu_wd;
            wb_if.ld_issue    = vecs[i].ld_v;
            wb_if.ld_issue_rd = vecs[i].ld_rd;
            wb_if.lsu_valid   = vecs[i].lsu_v;
            wb_if.lsu_rd      = vecs[i].lsu_rd;
            wb_if.lsu_wd      = vecs[i].lsu_wd;
`ifdef RF_WB_BYPASS_EN
            wb_if.ra1 = vecs[i].ra1;
            wb_if.ra2 = vecs[i].ra2;
`endif
            #3;
            chk("alu_ready", i, {31'd0, wb_if.alu_ready}, {31'd0, vecs[i].e_alu_rdy});
            chk("lsu_ready", i, {31'd0, wb_if.lsu_ready}, {31'd0, vecs[i].e_lsu_rdy});
            chk("we3",       i, {31'd0, wb_if.we3},       {31'd0, vecs[i].e_we3});
            chk("a3",        i, {27'd0, wb_if.a3},        {27'd0, vecs[i].e_a3});
            chk("wd3",       i, wb_if.wd3,                vecs[i].e_wd3);
            chk("pending",   i, wb_if.pending,            vecs[i].e_pend);
`ifdef RF_WB_BYPASS_EN
            chk("rd1_fwd",   i, wb_if.rd1_fwd,            vecs[i].e_fwd1);
            chk("rd2_fwd",   i, wb_if.rd2_fwd,            vecs[i].e_fwd2);
`endif
            @(posedge clk);
            #1;
        end
        drive_idle();

        // Register file contents after the table
        chk("rf_x5",  0, rf_model[5],  32'h0000_00AA);
        chk("rf_x4",  0, rf_model[4],  32'h44);
        chk("rf_x10", 0, rf_model[10], 32'h1000);
        chk("rf_x7",  0, rf_model[7],  32'h77);
        chk("rf_x9",  0, rf_model[9],  32'h5);
        chk("rf_x0",  0, rf_model[0],  32'h0);

        // ---------------- asynchronous reset mid-stream ----------------
        wb_if.ld_issue    = 1'b1;
        wb_if.ld_issue_rd = 5'd5;
        wb_if.alu_valid   = 1'b1;
        wb_if.alu_rd      = 5'd3;
        wb_if.alu_wd      = 32'h3333;
        @(posedge clk);
        #1;
        drive_idle();
        wb_if.lsu_valid = 1'b1;
        wb_if.lsu_rd    = 5'd12;
        wb_if.lsu_wd    = 32'hC;
        #1;
        chk("pre_rst_pending", 0, wb_if.pending,            32'h0000_0020);
        chk("pre_rst_we3",     0, {31'd0, wb_if.we3},       32'd1);
        chk("pre_rst_a3",      0, {27'd0, wb_if.a3},        32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we3",       0, {31'd0, wb_if.we3},       32'd0);
        chk("mid_rst_a3",        0, {27'd0, wb_if.a3},        32'd0);
        chk("mid_rst_wd3",       0, wb_if.wd3,                32'd0);
        chk("mid_rst_pending",   0, wb_if.pending,            32'd0);
        chk("mid_rst_alu_ready", 0, {31'd0, wb_if.alu_ready}, 32'd0);
        chk("mid_rst_lsu_ready", 0, {31'd0, wb_if.lsu_ready}, 32'd0);
        drive_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        chk("post_rst_we3",       0, {31'd0, wb_if.we3},       32'd0);
        chk("post_rst_lsu_ready", 0, {31'd0, wb_if.lsu_ready}, 32'd1);
        chk("post_rst_alu_ready", 0, {31'd0, wb_if.alu_ready}, 32'd1);
        chk("post_rst_pending",   0, wb_if.pending,            32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_idle_we3",  0, {31'd0, wb_if.we3},       32'd0);
        chk("rf_x3_untouched",    0, rf_model[3],              32'h33);

        // New traffic after reset: single ALU write to x6
        wb_if.alu_valid = 1'b1;
        wb_if.alu_rd    = 5'd6;
        wb_if.alu_wd    = 32'h66;
        @(posedge clk);
        #1;
        drive_idle();
        #2;
        chk("new_we3", 0, {31'd0, wb_if.we3}, 32'd1);
        chk("new_a3",  0, {27'd0, wb_if.a3},  32'd6);
        chk("new_wd3", 0, wb_if.wd3,          32'h66);
        @(posedge clk);
        #1;
        chk("rf_x6", 0, rf_model[6], 32'h66);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
